// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the main-memory arbiter.
//   arb_state_t : arbiter sequencing state (IDLE -> BUSY -> DONE -> IDLE)
//   arb_owner_t : which requester owns the memory (instruction fetch or data)
//   MEM_LAT_DEFAULT : default fixed memory access latency in cycles
//   CNT_W       : width of the latency down-counter (covers latencies 1..15)
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFETCH = 1'b0,
    OWN_DATA   = 1'b1
  } arb_owner_t;

  localparam int MEM_LAT_DEFAULT = 4;
  localparam int CNT_W           = 4;

  // Round-robin tie break: the side that did not win the previous grant
  function automatic arb_owner_t rr_pick(input arb_owner_t last);
    arb_owner_t pick;
    if (last == OWN_IFETCH) begin
      pick = OWN_DATA;
    end else begin
      pick = OWN_IFETCH;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times one fixed-latency memory access.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_load    : load i_value (takes priority over i_dec)
//   i_value   : value to load (latency - 1)
//   i_dec     : decrement by one
//   o_zero    : count has reached zero (last access cycle)
module mem_lat_counter
  import wisc_mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load, decrement or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported main memory between instruction fetch (i_*) and the
// data stage (d_*). One access at a time: grant in IDLE, MEM_LAT cycles of
// BUSY with the latched command on mem_*, then one DONE cycle carrying the
// owner's rdy pulse. Ties are broken round-robin (first tie after reset: data).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr             : fetch read request and address
//   i_rdy/i_rdata            : fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata: data request (we=1 store, 0 load)
//   d_rdy/d_rdata            : data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata : memory command (registered)
//   mem_rdata                : memory read data, valid in the last BUSY cycle
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  arb_owner_t        r_last_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_i_rdy;
  logic              r_d_rdy;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_cnt_zero;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  arb_owner_t        w_grant_owner;

  assign w_any_req  = i_req | d_req;
  assign w_cnt_load = (r_state == ARB_IDLE) & w_any_req;
  assign w_cnt_dec  = (r_state == ARB_BUSY) & ~w_cnt_zero;

  // Grant selection: single requester wins outright, a tie goes round-robin
  always_comb begin
    w_grant_owner = OWN_IFETCH;
    if (i_req && d_req) begin
      w_grant_owner = rr_pick(r_last_grant);
    end else if (d_req) begin
      w_grant_owner = OWN_DATA;
    end else begin
      w_grant_owner = OWN_IFETCH;
    end
  end

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_cnt_load),
    .i_value (LOAD_VAL),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_IFETCH;
      r_last_grant <= OWN_IFETCH;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
      r_i_rdy      <= 1'b0;
      r_d_rdy      <= 1'b0;
      r_i_rdata    <= {DATA_W{1'b0}};
      r_d_rdata    <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_i_rdy <= 1'b0;
          r_d_rdy <= 1'b0;
          if (w_any_req) begin
            // Latch the winner's command; mem_* stay stable for the whole access
            r_state      <= ARB_BUSY;
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            r_mem_en     <= 1'b1;
            if (w_grant_owner == OWN_DATA) begin
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= {DATA_W{1'b0}};
            end
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (w_cnt_zero) begin
            // Last access cycle: memory data is valid now
            r_state  <= ARB_DONE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_owner == OWN_DATA) begin
              r_d_rdy <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end else begin
                r_d_rdata <= r_d_rdata;
              end
            end else begin
              r_i_rdy   <= 1'b1;
              r_i_rdata <= mem_rdata;
            end
          end else begin
            r_state <= ARB_BUSY;
          end
        end
        ARB_DONE: begin
          // Requests seen here are the just-served ones still held; ignore them
          r_state <= ARB_IDLE;
          r_i_rdy <= 1'b0;
          r_d_rdy <= 1'b0;
        end
        default: begin
          r_state  <= ARB_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_i_rdy  <= 1'b0;
          r_d_rdy  <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdy     = r_i_rdy;
  assign i_rdata   = r_i_rdata;
  assign d_rdy     = r_d_rdy;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model (grant cycle + fixed latency
// arithmetic, round-robin on ties, sparse memory) compared every cycle, plus
// hand-computed literal checks for the directed scenarios and a MEM_LAT=1 build.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_rdata;

  logic        i_rdy, d_rdy, mem_en, mem_we;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic        l1_i_rdy, l1_d_rdy, l1_mem_en, l1_mem_we;
  logic [15:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(l1_i_rdy), .i_rdata(l1_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(l1_d_rdy), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = -1;

  // requester state, index 0 = fetch, 1 = data
  bit          want[2];
  bit          rdy_prev[2];
  bit          auto_mode[2];
  logic [15:0] rq_addr[2];
  bit          rq_we[2];
  logic [15:0] rq_wd[2];
  int          rnd_pct;

  // transaction-level arbiter model
  bit          have_txn;
  int          g_cyc;
  int          own;
  logic [15:0] t_addr;
  bit          t_we;
  logic [15:0] t_wd;
  int          next_free;
  int          last_own;
  logic [15:0] rdata_m[2];
  logic [15:0] mem_m[int];
  bit          hold_en;
  logic [15:0] hold_val;
  bit          chk_on;

  function automatic logic [15:0] memval(input logic [15:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [15:0] a, input bit we, input logic [15:0] wd);
    want[s]    = 1'b1;
    rq_addr[s] = a;
    rq_we[s]   = we;
    rq_wd[s]   = wd;
  endtask

  task automatic new_req(input int s);
    set_req(s, 16'h0100 + 16'($urandom_range(0, 15)),
            (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
  endtask

  // One cycle: compare this cycle's outputs, update requesters, model grant, drive memory
  task automatic step(input bit do_rst);
    bit en_exp;
    bit rdy_exp[2];
    bit dropped;
    @(negedge clk);
    cyc++;
    rdy_exp[0] = 1'b0;
    rdy_exp[1] = 1'b0;
    if (have_txn && cyc == g_cyc + L + 1) begin
      rdy_exp[own] = 1'b1;
      if (t_we) mem_m[int'(t_addr)] = t_wd;
      else      rdata_m[own] = memval(t_addr);
    end
    en_exp = have_txn && (cyc >= g_cyc + 1) && (cyc <= g_cyc + L);
    if (chk_on) begin
      chk("mem_en", {31'd0, mem_en}, {31'd0, en_exp});
      if (en_exp) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, t_we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, t_addr});
        if (t_we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, t_wd});
      end else begin
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end
      chk("i_rdy", {31'd0, i_rdy}, {31'd0, rdy_exp[0]});
      chk("d_rdy", {31'd0, d_rdy}, {31'd0, rdy_exp[1]});
      chk("i_rdata", {16'd0, i_rdata}, {16'd0, rdata_m[0]});
      chk("d_rdata", {16'd0, d_rdata}, {16'd0, rdata_m[1]});
    end
    if (have_txn && cyc == g_cyc + L + 1) have_txn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      dropped = 1'b0;
      if (rdy_prev[s]) begin
        want[s] = 1'b0;
        dropped = 1'b1;
      end
      if (!want[s] && !dropped && auto_mode[s] && ($urandom_range(0, 99) < rnd_pct)) new_req(s);
      rdy_prev[s] = rdy_exp[s];
    end
    i_req   = want[0];
    i_addr  = rq_addr[0];
    d_req   = want[1];
    d_we    = rq_we[1];
    d_addr  = rq_addr[1];
    d_wdata = rq_wd[1];
    rst     = do_rst;
    if (do_rst) begin
      have_txn   = 1'b0;
      next_free  = cyc + 1;
      last_own   = 0;
      rdata_m[0] = 16'h0000;
      rdata_m[1] = 16'h0000;
    end else if (cyc >= next_free && (want[0] || want[1])) begin
      if (want[0] && want[1]) own = 1 - last_own;
      else                    own = want[1] ? 1 : 0;
      last_own  = own;
      have_txn  = 1'b1;
      g_cyc     = cyc;
      next_free = cyc + L + 2;
      t_addr    = rq_addr[own];
      t_we      = (own == 1) ? rq_we[1] : 1'b0;
      t_wd      = rq_wd[own];
    end
    if (hold_en)                                      mem_rdata = hold_val;
    else if (have_txn && !t_we && cyc == g_cyc + L)   mem_rdata = memval(t_addr);
    else                                              mem_rdata = 16'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (!(want[0] || want[1] || have_txn)) break;
      step(1'b0);
    end
    chk("drain_idle", {29'd0, want[0], want[1], have_txn}, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
    for (int s = 0; s < 2; s++) begin
      want[s] = 1'b0; rdy_prev[s] = 1'b0; auto_mode[s] = 1'b0;
      rq_addr[s] = 16'h0; rq_we[s] = 1'b0; rq_wd[s] = 16'h0; rdata_m[s] = 16'h0;
    end
    have_txn = 1'b0; g_cyc = 0; own = 0; t_addr = 16'h0; t_we = 1'b0; t_wd = 16'h0;
    next_free = 0; last_own = 0; hold_en = 1'b0; hold_val = 16'h0; chk_on = 1'b0; rnd_pct = 0;

    step(1'b1);
    step(1'b1);
    chk_on = 1'b1;
    step(1'b0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);

    // Single fetch read; memory data held at 0xA5A5 so the MEM_LAT=1 build sees it too
    mem_m[16'h0010] = 16'hA5A5;
    hold_en = 1'b1; hold_val = 16'hA5A5;
    set_req(0, 16'h0010, 1'b0, 16'h0);
    step(1'b0);
    base = cyc;
    for (int r = 1; r <= 7; r++) begin
      step(1'b0);
      if (r >= 1 && r <= 4) chk("d1_mem_en", {31'd0, mem_en}, 32'd1);
      if (r == 5) begin
        chk("d1_i_rdy", {31'd0, i_rdy}, 32'd1);
        chk("d1_i_rdata", {16'd0, i_rdata}, 32'h0000A5A5);
        chk("d1_d_rdy", {31'd0, d_rdy}, 32'd0);
      end
      if (r == 1) begin
        chk("lat1_mem_en_c1", {31'd0, l1_mem_en}, 32'd1);
        chk("lat1_i_rdy_c1", {31'd0, l1_i_rdy}, 32'd0);
      end
      if (r == 2) begin
        chk("lat1_mem_en_c2", {31'd0, l1_mem_en}, 32'd0);
        chk("lat1_i_rdy_c2", {31'd0, l1_i_rdy}, 32'd1);
        chk("lat1_i_rdata", {16'd0, l1_i_rdata}, 32'h0000A5A5);
      end
    end
    hold_en = 1'b0;
    drain();

    // Single store
    set_req(1, 16'h0200, 1'b1, 16'h1234);
    step(1'b0);
    base = cyc;
    for (int r = 1; r <= 7; r++) begin
      step(1'b0);
      if (r >= 1 && r <= 4) begin
        chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_mem_addr", {16'd0, mem_addr}, 32'h00000200);
        chk("sw_mem_wdata", {16'd0, mem_wdata}, 32'h00001234);
      end
      if (r == 5) begin
        chk("sw_d_rdy", {31'd0, d_rdy}, 32'd1);
        chk("sw_d_rdata", {16'd0, d_rdata}, 32'd0);
        chk("sw_i_rdy", {31'd0, i_rdy}, 32'd0);
      end
    end
    drain();

    // Tie right after reset, then continuous contention: D, I, D, I
    step(1'b1);
    set_req(0, 16'h0010, 1'b0, 16'h0);
    set_req(1, 16'h0200, 1'b0, 16'h0);
    auto_mode[0] = 1'b1; auto_mode[1] = 1'b1; rnd_pct = 100;
    step(1'b0);
    base = cyc;
    for (int r = 1; r <= 24; r++) begin
      step(1'b0);
      if (r == 5) begin
        chk("tie_d_first", {31'd0, d_rdy}, 32'd1);
        chk("tie_i_wait", {31'd0, i_rdy}, 32'd0);
        chk("tie_d_rdata", {16'd0, d_rdata}, 32'h00001234);
      end
      if (r == 11) chk("rr_i_1", {31'd0, i_rdy}, 32'd1);
      if (r == 17) chk("rr_d_2", {31'd0, d_rdy}, 32'd1);
      if (r == 23) chk("rr_i_2", {31'd0, i_rdy}, 32'd1);
    end
    auto_mode[0] = 1'b0; auto_mode[1] = 1'b0;
    drain();

    // Reset in the second BUSY cycle aborts; held request restarts with full latency
    set_req(0, 16'h0033, 1'b0, 16'h0);
    step(1'b0);
    base = cyc;
    for (int r = 1; r <= 10; r++) begin
      step(r == 2);
      if (r == 3) chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
      if (r == 4) chk("reissue_mem_en", {31'd0, mem_en}, 32'd1);
      if (r == 5) chk("abort_no_rdy", {31'd0, i_rdy}, 32'd0);
      if (r == 8) chk("reissue_rdy", {31'd0, i_rdy}, 32'd1);
    end
    drain();

    // Random traffic with occasional resets
    auto_mode[0] = 1'b1; auto_mode[1] = 1'b1; rnd_pct = 30;
    for (int k = 0; k < 3000; k++) step($urandom_range(0, 299) == 0);
    auto_mode[0] = 1'b0; auto_mode[1] = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
